// File: rtl/spec_pkg.sv
// Shared widths and FSM encoding for the spectrum sample-buffer arbiter.
package spec_pkg;

  localparam int ABITS_DEF = 12;
  localparam int DBITS_DEF = 18;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } arb_state_e;

endpackage

// File: rtl/spec_sp_ram.sv
// Single-port sample RAM with registered read data; writes leave the output register untouched.
module spec_sp_ram #(
  parameter int ABITS = 12,
  parameter int DBITS = 18
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             en,
  input  logic             we,
  input  logic [ABITS-1:0] addr,
  input  logic [DBITS-1:0] wdata,
  output logic [DBITS-1:0] rdata
);

  logic [DBITS-1:0] mem [2**ABITS];

  always_ff @(posedge CLK) begin
    if (en && we) mem[addr] <= wdata;
  end

  // Only the output register is reset; array contents survive reset.
  always_ff @(posedge CLK) begin
    if (RST)              rdata <= '0;
    else if (en && !we)   rdata <= mem[addr];
  end

endmodule

// File: rtl/spec_buf_arbiter.sv
// Audio sample buffer: a streaming writer and a burst reader share one single-port RAM,
// with the writer's one-deep hold register always taking the port ahead of the reader.
module spec_buf_arbiter
  import spec_pkg::*;
#(
  parameter int ABITS     = ABITS_DEF,
  parameter int DBITS     = DBITS_DEF,
  parameter int OFFSET    = 400,
  parameter int BURST_LEN = 1024
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [DBITS-1:0] ADATA,
  input  logic             ADATARDY,
  input  logic             LINE_REQ,
  input  logic             CLR_FLAGS,
  output logic [DBITS-1:0] RD_DATA,
  output logic             RD_VALID,
  output logic             RD_LAST,
  output logic             BUSY,
  output logic             DROP,
  output logic [ABITS-1:0] WPTR
);

  localparam int               CBITS    = $clog2(BURST_LEN + 1);
  localparam logic [CBITS-1:0] LAST_CNT = CBITS'(BURST_LEN - 1);
  localparam logic [ABITS-1:0] OFS      = ABITS'(OFFSET % (2**ABITS));

  arb_state_e       state, state_nxt;
  logic [ABITS-1:0] rd_addr;
  logic [CBITS-1:0] cnt;
  logic             hold_vld;
  logic [ABITS-1:0] hold_addr;
  logic [DBITS-1:0] hold_data;
  logic             issue;
  logic             ram_en, ram_we;
  logic [ABITS-1:0] ram_addr;

  // A pending hold always owns the port, so the reader simply skips that cycle.
  assign issue    = (state == ST_RUN) && !hold_vld;
  assign ram_we   = hold_vld && !RST;
  assign ram_en   = ram_we || issue;
  assign ram_addr = hold_vld ? hold_addr : rd_addr;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (LINE_REQ) state_nxt = ST_RUN;
      ST_RUN:   if (issue && cnt == LAST_CNT) state_nxt = ST_DRAIN;
      ST_DRAIN: state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= ST_IDLE;
      WPTR      <= '0;
      hold_vld  <= 1'b0;
      hold_addr <= '0;
      hold_data <= '0;
      rd_addr   <= '0;
      cnt       <= '0;
      RD_VALID  <= 1'b0;
      RD_LAST   <= 1'b0;
      BUSY      <= 1'b0;
      DROP      <= 1'b0;
    end else begin
      state <= state_nxt;
      BUSY  <= (state_nxt != ST_IDLE);

      // The hold is committed by the RAM this cycle, so reloading it here never loses data.
      hold_vld <= ADATARDY;
      if (ADATARDY) begin
        hold_addr <= WPTR;
        hold_data <= ADATA;
        WPTR      <= WPTR + ABITS'(1);
      end

      if (state == ST_IDLE && LINE_REQ) begin
        rd_addr <= WPTR + OFS;
        cnt     <= '0;
      end else if (issue) begin
        rd_addr <= rd_addr + ABITS'(1);
        cnt     <= cnt + CBITS'(1);
      end

      RD_VALID <= issue;
      RD_LAST  <= issue && (cnt == LAST_CNT);

      if (LINE_REQ && state != ST_IDLE) DROP <= 1'b1;
      else if (CLR_FLAGS)               DROP <= 1'b0;
    end
  end

  spec_sp_ram #(
    .ABITS (ABITS),
    .DBITS (DBITS)
  ) u_ram (
    .CLK   (CLK),
    .RST   (RST),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (hold_data),
    .rdata (RD_DATA)
  );

endmodule

// File: tb/tb_spec_buf_arbiter.sv
// Self-checking bench: array model of RAM contents and write pointer, beat monitor, scenario tasks.
module tb_spec_buf_arbiter;

  localparam int AB    = 12;
  localparam int DB    = 18;
  localparam int OFS   = 400;
  localparam int BL    = 64;
  localparam int DEPTH = 4096;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic [DB-1:0] ADATA = '0;
  logic          ADATARDY = 1'b0;
  logic          LINE_REQ = 1'b0;
  logic          CLR_FLAGS = 1'b0;
  logic [DB-1:0] RD_DATA;
  logic          RD_VALID, RD_LAST, BUSY, DROP;
  logic [AB-1:0] WPTR;

  spec_buf_arbiter #(.ABITS(AB), .DBITS(DB), .OFFSET(OFS), .BURST_LEN(BL)) dut (
    .CLK(CLK), .RST(RST), .ADATA(ADATA), .ADATARDY(ADATARDY), .LINE_REQ(LINE_REQ),
    .CLR_FLAGS(CLR_FLAGS), .RD_DATA(RD_DATA), .RD_VALID(RD_VALID), .RD_LAST(RD_LAST),
    .BUSY(BUSY), .DROP(DROP), .WPTR(WPTR)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // Reference model: buffer contents and write pointer.
  logic [DB-1:0] mem_ref [DEPTH];
  int wptr_m = 0;

  typedef struct {
    logic [DB-1:0] d;
    logic          last;
    int            cyc;
  } beat_t;
  beat_t beats[$];
  int   cyc = 0;
  int   busy_total = 0;
  int   stall_viol = 0;
  logic adr_prev = 1'b0;

  // A read cannot complete right after a cycle whose write hold was committing.
  always @(posedge CLK) begin
    #1;
    cyc++;
    if (RD_VALID === 1'b1) begin
      if (adr_prev) stall_viol++;
      beats.push_back('{RD_DATA, RD_LAST, cyc});
    end
    if (BUSY === 1'b1) busy_total++;
    adr_prev = ADATARDY;
  end

  task automatic drive(input logic a, input logic l, input logic c);
    ADATARDY  = a;
    LINE_REQ  = l;
    CLR_FLAGS = c;
    ADATA     = DB'($urandom);
    if (a && !RST) begin
      mem_ref[wptr_m] = ADATA;
      wptr_m = (wptr_m + 1) % DEPTH;
    end
    @(negedge CLK);
    ADATARDY  = 1'b0;
    LINE_REQ  = 1'b0;
    CLR_FLAGS = 1'b0;
  endtask

  // mode 0: no writes, 1: write every 2nd cycle, 2: random writes and CLR_FLAGS
  task automatic run_until(input int target, input int mode, output bit timeout);
    int   n;
    logic a;
    n = 0;
    timeout = 1'b0;
    while (beats.size() < target) begin
      if (n >= 2000) begin timeout = 1'b1; break; end
      case (mode)
        1:       a = (n % 2 == 0);
        2:       a = ($urandom_range(9) < 3);
        default: a = 1'b0;
      endcase
      drive(a, 1'b0, (mode == 2) ? 1'($urandom_range(1)) : 1'b0);
      n++;
    end
    drive(0, 0, 0);
    drive(0, 0, 0);
  endtask

  task automatic test_reset;
    RST = 1'b1;
    repeat (3) drive(0, 0, 0);
    checks++; if (BUSY !== 1'b0)     begin errors++; $display("FAIL reset_busy got %b want 0", BUSY); end
    checks++; if (RD_VALID !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", RD_VALID); end
    checks++; if (RD_LAST !== 1'b0)  begin errors++; $display("FAIL reset_last got %b want 0", RD_LAST); end
    checks++; if (DROP !== 1'b0)     begin errors++; $display("FAIL reset_drop got %b want 0", DROP); end
    checks++; if (WPTR !== '0)       begin errors++; $display("FAIL reset_wptr got %0d want 0", WPTR); end
    checks++; if (RD_DATA !== '0)    begin errors++; $display("FAIL reset_data got %h want 0", RD_DATA); end
    RST = 1'b0;
    wptr_m = 0;
    // Fill the whole buffer back-to-back so every later read has known contents.
    for (int i = 0; i < DEPTH; i++) begin
      drive(1, 0, 0);
      if (i == 99) begin
        checks++; if (WPTR !== AB'(wptr_m)) begin errors++; $display("FAIL fill_wptr got %0d want %0d", WPTR, wptr_m); end
      end
    end
    drive(0, 0, 0);
    checks++; if (WPTR !== AB'(wptr_m)) begin errors++; $display("FAIL fill_wrap_wptr got %0d want %0d", WPTR, wptr_m); end
  endtask

  task automatic test_basic;
    int start, base, b0, req;
    bit to;
    for (int i = 0; i < 10; i++) begin
      drive(1, 0, 0);
      repeat (3) drive(0, 0, 0);
    end
    checks++; if (WPTR !== AB'(wptr_m)) begin errors++; $display("FAIL basic_wptr got %0d want %0d", WPTR, wptr_m); end
    start = (wptr_m + OFS) % DEPTH;
    base = beats.size();
    b0 = busy_total;
    drive(0, 1, 0);
    req = cyc;
    checks++; if (BUSY !== 1'b1) begin errors++; $display("FAIL basic_busy_start got %b want 1", BUSY); end
    run_until(base + BL, 0, to);
    checks++; if (to) begin errors++; $display("FAIL basic_timeout beats %0d want %0d", beats.size() - base, BL); end
    checks++; if (beats.size() != base + BL) begin errors++; $display("FAIL basic_count got %0d want %0d", beats.size() - base, BL); end
    checks++; if (busy_total - b0 != BL + 1) begin errors++; $display("FAIL basic_busy_len got %0d want %0d", busy_total - b0, BL + 1); end
    for (int j = 0; j < BL && base + j < beats.size(); j++) begin
      checks++;
      if (beats[base+j].d !== mem_ref[(start+j)%DEPTH] || beats[base+j].last !== logic'(j == BL-1)
          || beats[base+j].cyc != req + 1 + j) begin
        errors++;
        $display("FAIL basic_beat%0d got %h/%b@%0d want %h/%b@%0d", j, beats[base+j].d, beats[base+j].last,
                 beats[base+j].cyc, mem_ref[(start+j)%DEPTH], logic'(j == BL-1), req + 1 + j);
      end
    end
    checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL basic_busy_end got %b want 0", BUSY); end
  endtask

  task automatic test_rst_mid;
    int start, base, seen;
    bit to;
    base = beats.size();
    drive(0, 1, 0);
    repeat (4) drive(0, 0, 0);
    RST = 1'b1;
    drive(0, 0, 0);
    RST = 1'b0;
    wptr_m = 0;
    checks++; if (BUSY !== 1'b0)     begin errors++; $display("FAIL rstmid_busy got %b want 0", BUSY); end
    checks++; if (RD_VALID !== 1'b0) begin errors++; $display("FAIL rstmid_valid got %b want 0", RD_VALID); end
    checks++; if (WPTR !== '0)       begin errors++; $display("FAIL rstmid_wptr got %0d want 0", WPTR); end
    seen = beats.size();
    checks++; if (seen - base > 4) begin errors++; $display("FAIL rstmid_partial got %0d beats want <=4", seen - base); end
    drive(0, 0, 0);
    checks++; if (beats.size() != seen) begin errors++; $display("FAIL rstmid_no_valid got %0d new beats want 0", beats.size() - seen); end
    start = (wptr_m + OFS) % DEPTH;
    base = beats.size();
    drive(0, 1, 0);
    run_until(base + BL, 0, to);
    checks++; if (to || beats.size() != base + BL) begin errors++; $display("FAIL rstmid_count got %0d want %0d", beats.size() - base, BL); end
    for (int j = 0; j < BL && base + j < beats.size(); j++) begin
      checks++;
      if (beats[base+j].d !== mem_ref[(start+j)%DEPTH] || beats[base+j].last !== logic'(j == BL-1)) begin
        errors++;
        $display("FAIL rstmid_beat%0d got %h/%b want %h/%b", j, beats[base+j].d, beats[base+j].last,
                 mem_ref[(start+j)%DEPTH], logic'(j == BL-1));
      end
    end
  endtask

  task automatic test_stall_half;
    int start, base, b0, v0;
    bit to;
    start = (wptr_m + OFS) % DEPTH;
    base = beats.size();
    b0 = busy_total;
    v0 = stall_viol;
    drive(0, 1, 0);
    run_until(base + BL, 1, to);
    checks++; if (to || beats.size() != base + BL) begin errors++; $display("FAIL half_count got %0d want %0d", beats.size() - base, BL); end
    checks++; if (busy_total - b0 != 2 * BL) begin errors++; $display("FAIL half_busy_len got %0d want %0d", busy_total - b0, 2 * BL); end
    checks++; if (stall_viol != v0) begin errors++; $display("FAIL half_read_during_commit got %0d want 0", stall_viol - v0); end
    checks++; if (WPTR !== AB'(wptr_m)) begin errors++; $display("FAIL half_wptr got %0d want %0d", WPTR, wptr_m); end
    for (int j = 0; j < BL && base + j < beats.size(); j++) begin
      checks++;
      if (beats[base+j].d !== mem_ref[(start+j)%DEPTH] || beats[base+j].last !== logic'(j == BL-1)) begin
        errors++;
        $display("FAIL half_beat%0d got %h/%b want %h/%b", j, beats[base+j].d, beats[base+j].last,
                 mem_ref[(start+j)%DEPTH], logic'(j == BL-1));
      end
    end
  endtask

  task automatic test_stall_all;
    int start, base, b0, v0;
    bit to;
    start = (wptr_m + OFS) % DEPTH;
    base = beats.size();
    b0 = busy_total;
    v0 = stall_viol;
    drive(0, 1, 0);
    repeat (3) drive(0, 0, 0);
    repeat (20) drive(1, 0, 0);
    checks++; if (beats.size() - base != 4) begin errors++; $display("FAIL full_stall_beats got %0d want 4", beats.size() - base); end
    run_until(base + BL, 0, to);
    checks++; if (to || beats.size() != base + BL) begin errors++; $display("FAIL full_count got %0d want %0d", beats.size() - base, BL); end
    checks++; if (busy_total - b0 != BL + 21) begin errors++; $display("FAIL full_busy_len got %0d want %0d", busy_total - b0, BL + 21); end
    checks++; if (stall_viol != v0) begin errors++; $display("FAIL full_read_during_commit got %0d want 0", stall_viol - v0); end
    checks++; if (WPTR !== AB'(wptr_m)) begin errors++; $display("FAIL full_wptr got %0d want %0d", WPTR, wptr_m); end
    for (int j = 0; j < BL && base + j < beats.size(); j++) begin
      checks++;
      if (beats[base+j].d !== mem_ref[(start+j)%DEPTH] || beats[base+j].last !== logic'(j == BL-1)) begin
        errors++;
        $display("FAIL full_beat%0d got %h/%b want %h/%b", j, beats[base+j].d, beats[base+j].last,
                 mem_ref[(start+j)%DEPTH], logic'(j == BL-1));
      end
    end
  endtask

  task automatic test_drop;
    int start, base;
    bit to;
    checks++; if (DROP !== 1'b0) begin errors++; $display("FAIL drop_init got %b want 0", DROP); end
    start = (wptr_m + OFS) % DEPTH;
    base = beats.size();
    drive(0, 1, 0);
    repeat (5) drive(0, 0, 0);
    drive(0, 1, 0);
    checks++; if (DROP !== 1'b1 || BUSY !== 1'b1) begin errors++; $display("FAIL drop_set got %b/%b want 1/1", DROP, BUSY); end
    drive(0, 1, 1);
    checks++; if (DROP !== 1'b1) begin errors++; $display("FAIL drop_req_beats_clr got %b want 1", DROP); end
    drive(0, 0, 1);
    checks++; if (DROP !== 1'b0) begin errors++; $display("FAIL drop_clr got %b want 0", DROP); end
    run_until(base + BL, 0, to);
    checks++; if (to || beats.size() != base + BL) begin errors++; $display("FAIL drop_count got %0d want %0d", beats.size() - base, BL); end
    for (int j = 0; j < BL && base + j < beats.size(); j++) begin
      checks++;
      if (beats[base+j].d !== mem_ref[(start+j)%DEPTH] || beats[base+j].last !== logic'(j == BL-1)) begin
        errors++;
        $display("FAIL drop_beat%0d got %h/%b want %h/%b", j, beats[base+j].d, beats[base+j].last,
                 mem_ref[(start+j)%DEPTH], logic'(j == BL-1));
      end
    end
    start = (wptr_m + OFS) % DEPTH;
    base = beats.size();
    drive(0, 1, 0);
    checks++; if (BUSY !== 1'b1 || DROP !== 1'b0) begin errors++; $display("FAIL drop_next_accept got %b/%b want 1/0", BUSY, DROP); end
    run_until(base + BL, 0, to);
    checks++; if (to || beats.size() != base + BL) begin errors++; $display("FAIL drop_next_count got %0d want %0d", beats.size() - base, BL); end
    if (base < beats.size()) begin
      checks++;
      if (beats[base].d !== mem_ref[start]) begin errors++; $display("FAIL drop_next_first got %h want %h", beats[base].d, mem_ref[start]); end
    end
  endtask

  // Concurrent write and request near the top of the buffer: read must wrap 4095 -> 0.
  task automatic test_wrap;
    int start, base, b0, n;
    bit to;
    n = (3680 - wptr_m + DEPTH) % DEPTH;
    for (int i = 0; i < n; i++) drive(1, 0, 0);
    start = (wptr_m + OFS) % DEPTH;
    base = beats.size();
    b0 = busy_total;
    drive(1, 1, 0);
    run_until(base + BL, 0, to);
    checks++; if (to || beats.size() != base + BL) begin errors++; $display("FAIL wrap_count got %0d want %0d", beats.size() - base, BL); end
    checks++; if (busy_total - b0 != BL + 2) begin errors++; $display("FAIL wrap_busy_len got %0d want %0d", busy_total - b0, BL + 2); end
    checks++; if (WPTR !== AB'(wptr_m)) begin errors++; $display("FAIL wrap_wptr got %0d want %0d", WPTR, wptr_m); end
    for (int j = 0; j < BL && base + j < beats.size(); j++) begin
      checks++;
      if (beats[base+j].d !== mem_ref[(start+j)%DEPTH] || beats[base+j].last !== logic'(j == BL-1)) begin
        errors++;
        $display("FAIL wrap_beat%0d addr %0d got %h/%b want %h/%b", j, (start+j)%DEPTH, beats[base+j].d,
                 beats[base+j].last, mem_ref[(start+j)%DEPTH], logic'(j == BL-1));
      end
    end
  endtask

  task automatic test_random;
    int start, base, v0, gap;
    bit to;
    v0 = stall_viol;
    for (int r = 0; r < 4; r++) begin
      gap = $urandom_range(8);
      for (int i = 0; i < gap; i++) drive(1'($urandom_range(1)), 0, 0);
      start = (wptr_m + OFS) % DEPTH;
      base = beats.size();
      drive(1'($urandom_range(1)), 1, 0);
      run_until(base + BL, 2, to);
      checks++; if (to || beats.size() != base + BL) begin errors++; $display("FAIL rand%0d_count got %0d want %0d", r, beats.size() - base, BL); end
      for (int j = 0; j < BL && base + j < beats.size(); j++) begin
        checks++;
        if (beats[base+j].d !== mem_ref[(start+j)%DEPTH] || beats[base+j].last !== logic'(j == BL-1)) begin
          errors++;
          $display("FAIL rand%0d_beat%0d got %h/%b want %h/%b", r, j, beats[base+j].d, beats[base+j].last,
                   mem_ref[(start+j)%DEPTH], logic'(j == BL-1));
        end
      end
      checks++; if (WPTR !== AB'(wptr_m)) begin errors++; $display("FAIL rand%0d_wptr got %0d want %0d", r, WPTR, wptr_m); end
    end
    checks++; if (stall_viol != v0) begin errors++; $display("FAIL rand_read_during_commit got %0d want 0", stall_viol - v0); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_rst_mid;
    test_stall_half;
    test_stall_all;
    test_drop;
    test_wrap;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog sim time exceeded, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
